// File: rtl/boton_dir_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: the debounce state
// encoding and a helper that sizes the debounce counter.
package boton_dir_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } btn_state_t;

  // Counter must hold 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/boton_dir_conditioner_sync_2ff.sv
// Two-stage single-bit synchroniser with synchronous clear to 0.
// Generic enough to reuse for other asynchronous board pins.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Shift the asynchronous input through two flops; both clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/boton_dir_conditioner.sv
// Push-button conditioner: polarity fix, 2-FF synchroniser, debounce FSM,
// registered press/release pulses and a direction bit that toggles per press.
module boton_dir_conditioner
  import boton_dir_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 500000,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter bit DIR_RESET    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic dir
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       p;
  logic       btn_s;

  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             dir_reg, dir_next;

  // Normalise so that 1 always means "pressed" before crossing domains.
  assign p = btn_raw ^ ACTIVE_LOW;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (p),
    .q   (btn_s)
  );

  // State, counter and all outputs are registered so the outputs never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RELEASED;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      dir_reg     <= DIR_RESET;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      dir_reg     <= dir_next;
    end
  end

  // Debounce transitions; pulses and dir are computed on the accepting edge
  // so they appear together with the new stable state.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    dir_next     = dir_reg;
    case (state_reg)
      ST_RELEASED: begin
        if (btn_s) begin
          state_next = ST_PRESS_CHK;
          cnt_next   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!btn_s) begin
          state_next = ST_RELEASED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_PRESSED;
          press_next = 1'b1;
          dir_next   = ~dir_reg;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_next = ST_RELEASE_CHK;
          cnt_next   = '0;
        end
      end
      ST_RELEASE_CHK: begin
        if (btn_s) begin
          state_next = ST_PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = ST_RELEASED;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_RELEASED;
        cnt_next   = '0;
      end
    endcase
    level_next = (state_next == ST_PRESSED) || (state_next == ST_RELEASE_CHK);
  end

  assign btn_level   = level_reg;
  assign btn_press   = press_reg;
  assign btn_release = release_reg;
  assign dir         = dir_reg;

endmodule

// File: tb/tb_boton_dir_conditioner.sv
// Bench for boton_dir_conditioner. Two instances share one stimulus stream:
// an active-high one and an active-low one fed the inverted pin (with the
// opposite dir reset value). A behavioural model predicts accepted presses
// and releases; a monitor pops the scoreboard whenever a pulse appears.
module tb_boton_dir_conditioner;

  localparam int N = 4;

  typedef struct {
    bit is_press;
    int cycle;
    bit dir_after;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic btn_raw_al;
  logic lvl0, prs0, rel0, dir0;
  logic lvl1, prs1, rel1, dir1;

  assign btn_raw_al = ~btn_raw;

  boton_dir_conditioner #(.DEBOUNCE_CNT(N), .ACTIVE_LOW(1'b0), .DIR_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0), .dir(dir0)
  );

  boton_dir_conditioner #(.DEBOUNCE_CNT(N), .ACTIVE_LOW(1'b1), .DIR_RESET(1'b1)) dut_al (
    .clk(clk), .rst(rst), .btn_raw(btn_raw_al),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1), .dir(dir1)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cycle    = 0;
  bit  checking = 0;
  bit  done     = 0;
  ev_t q[$];

  // Model state: synchronised samples, accepted level, run of disagreeing samples.
  bit m_s1, m_s2, m_level, m_dir;
  int m_run;
  bit exp_press, exp_release;

  // Accepted level flips once the synchronised input has disagreed with it
  // for N+1 consecutive edges (entry into the check state plus N counts).
  task automatic step(input logic raw, input logic r);
    ev_t e;
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    cycle++;
    exp_press   = 0;
    exp_release = 0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_dir = 0;
      checking = 1;
    end else begin
      if (m_s2 != m_level) begin
        m_run++;
        if (m_run == N + 1) begin
          m_level = ~m_level;
          m_run   = 0;
          if (m_level) begin
            m_dir = ~m_dir;
            exp_press = 1;
          end else begin
            exp_release = 1;
          end
          e.is_press  = m_level;
          e.cycle     = cycle;
          e.dir_after = m_dir;
          q.push_back(e);
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", name, cycle, act, req);
    end
  endtask

  // Monitor: per-cycle level/dir checks, scoreboard pop on every pulse.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (checking) begin
        check("level", lvl0, m_level);
        check("dir", dir0, m_dir);
        check("level_al", lvl1, m_level);
        check("dir_al", dir1, ~m_dir);
        check("press_al", prs1, exp_press);
        check("release_al", rel1, exp_release);
        if (prs0 === 1'b1 && rel0 === 1'b1) begin
          n_checks++; n_fail++;
          $display("FAIL both_pulses cycle %0d: got press and release together, expected at most one", cycle);
        end else if (prs0 === 1'b1 || rel0 === 1'b1) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse cycle %0d: got press=%0b release=%0b, expected none", cycle, prs0, rel0);
          end else begin
            e = q.pop_front();
            if (e.is_press != prs0 || e.cycle != cycle) begin
              n_fail++;
              $display("FAIL pulse cycle %0d: got press=%0b, expected press=%0b at cycle %0d", cycle, prs0, e.is_press, e.cycle);
            end else begin
              $display("%s accepted at cycle %0d dir=%0b", e.is_press ? "press  " : "release", cycle, dir0);
            end
            check("pulse_dir", dir0, e.dir_after);
          end
        end
        while (q.size() > 0 && q[0].cycle < cycle) begin
          e = q.pop_front();
          n_checks++; n_fail++;
          $display("FAIL missing_pulse: got no pulse, expected press=%0b at cycle %0d", e.is_press, e.cycle);
        end
      end
      if (done) break;
    end
  end

  initial begin
    btn_raw = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    // Reset then idle.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    hold(1'b0, 20);
    // Clean press held, release, second press, release.
    hold(1'b1, 50);
    hold(1'b0, 10);
    hold(1'b1, 20);
    hold(1'b0, 20);
    // Bounce rejection then a held press (dir -> 1), then release.
    hold(1'b1, 3); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1);
    hold(1'b1, 20);
    hold(1'b0, 20);
    // Reset while in PRESS_CHK with cnt = 2, button still held afterwards.
    hold(1'b1, 5);
    step(1'b1, 1'b1);
    hold(1'b1, 20);
    hold(1'b0, 20);
    // Random bursts, some long enough to be accepted, rare resets.
    for (int b = 0; b < 300; b++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 7);
      for (int i = 0; i < len; i++)
        step(v, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    hold(1'b0, 20);
    done = 1;
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending events, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
